// File: rtl/pipe_ctrl.sv
// In-order pipeline control: a STAGES-deep register chain with stall, partial flush,
// operand forwarding lookup and a saturating counter of flush-killed entries.
module pipe_ctrl #(
  parameter int WIDTH       = 64,
  parameter int STAGES      = 2,
  parameter int ADDR_W      = 8,
  parameter int FLUSH_DEPTH = STAGES
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [WIDTH-1:0]             i_in,
  input  logic                         i_in_valid,
  input  logic [ADDR_W-1:0]            i_in_dst,
  input  logic                         i_in_wr,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic [ADDR_W-1:0]            i_ra_addr,
  input  logic [ADDR_W-1:0]            i_rb_addr,
  output logic [WIDTH-1:0]             o_out,
  output logic                         o_out_valid,
  output logic [ADDR_W-1:0]            o_out_dst,
  output logic                         o_out_wr,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd_a,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd_b,
  output logic [STAGES-1:0]            o_stage_valid,
  output logic [7:0]                   o_kill_cnt
);

  localparam int FW = $clog2(STAGES+1);

  logic [WIDTH-1:0]  payload_q [STAGES];
  logic [WIDTH-1:0]  payload_d [STAGES];
  logic [ADDR_W-1:0] dst_q     [STAGES];
  logic [ADDR_W-1:0] dst_d     [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wr_q, wr_d;
  logic [7:0]        killCnt_q, killCnt_d;
  logic [8:0]        killSum;

  // Invalid stages always carry all-zero fields, so gating on the keep bit is enough
  // to turn any killed or empty upstream slot into a NOP bubble.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      payload_d[s] = payload_q[s];
      dst_d[s]     = dst_q[s];
      valid_d[s]   = valid_q[s];
      wr_d[s]      = wr_q[s];
    end

    if (i_flush && FLUSH_DEPTH >= 1) begin
      payload_d[0] = '0;
      dst_d[0]     = '0;
      valid_d[0]   = 1'b0;
      wr_d[0]      = 1'b0;
    end else if (!i_stall) begin
      payload_d[0] = (i_in_valid && !i_flush) ? i_in : '0;
      dst_d[0]     = (i_in_valid && !i_flush) ? i_in_dst : '0;
      valid_d[0]   = i_in_valid && !i_flush;
      wr_d[0]      = i_in_valid && !i_flush && i_in_wr;
    end

    for (int s = 1; s < STAGES; s++) begin
      if (i_flush && s < FLUSH_DEPTH) begin
        payload_d[s] = '0;
        dst_d[s]     = '0;
        valid_d[s]   = 1'b0;
        wr_d[s]      = 1'b0;
      end else if (!i_stall) begin
        if (i_flush && s <= FLUSH_DEPTH) begin
          payload_d[s] = '0;
          dst_d[s]     = '0;
          valid_d[s]   = 1'b0;
          wr_d[s]      = 1'b0;
        end else begin
          payload_d[s] = payload_q[s-1];
          dst_d[s]     = dst_q[s-1];
          valid_d[s]   = valid_q[s-1];
          wr_d[s]      = wr_q[s-1];
        end
      end
    end
  end

  always_comb begin
    killSum = {1'b0, killCnt_q};
    if (i_flush) begin
      for (int s = 0; s < FLUSH_DEPTH; s++) begin
        killSum = killSum + {8'd0, valid_q[s]};
      end
      killSum = killSum + {8'd0, i_in_valid};
    end
    killCnt_d = killSum[8] ? 8'hFF : killSum[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < STAGES; s++) begin
        payload_q[s] <= '0;
        dst_q[s]     <= '0;
      end
      valid_q   <= '0;
      wr_q      <= '0;
      killCnt_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        payload_q[s] <= payload_d[s];
        dst_q[s]     <= dst_d[s];
      end
      valid_q   <= valid_d;
      wr_q      <= wr_d;
      killCnt_q <= killCnt_d;
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    o_fwd_a = '0;
    o_fwd_b = '0;
    for (int s = STAGES-1; s >= 0; s--) begin
      if (valid_q[s] && wr_q[s] && dst_q[s] == i_ra_addr) o_fwd_a = FW'(s+1);
      if (valid_q[s] && wr_q[s] && dst_q[s] == i_rb_addr) o_fwd_b = FW'(s+1);
    end
  end

  assign o_out         = payload_q[STAGES-1];
  assign o_out_valid   = valid_q[STAGES-1];
  assign o_out_dst     = dst_q[STAGES-1];
  assign o_out_wr      = wr_q[STAGES-1];
  assign o_stage_valid = valid_q;
  assign o_kill_cnt    = killCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=2, WIDTH=8, ADDR_W=8, FLUSH_DEPTH=2):
// streaming, stall, flush, forwarding, kill-count saturation and async reset.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;
  logic [7:0] inDst;
  logic       inWr;
  logic       stall;
  logic       flush;
  logic [7:0] raAddr;
  logic [7:0] rbAddr;
  logic [7:0] outData;
  logic       outValid;
  logic [7:0] outDst;
  logic       outWr;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic [1:0] stageValid;
  logic [7:0] killCnt;

  int compared   = 0;
  int mismatched = 0;

  pipe_ctrl #(.WIDTH(8), .STAGES(2), .ADDR_W(8), .FLUSH_DEPTH(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in         (inData),
    .i_in_valid   (inValid),
    .i_in_dst     (inDst),
    .i_in_wr      (inWr),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_ra_addr    (raAddr),
    .i_rb_addr    (rbAddr),
    .o_out        (outData),
    .o_out_valid  (outValid),
    .o_out_dst    (outDst),
    .o_out_wr     (outWr),
    .o_fwd_a      (fwdA),
    .o_fwd_b      (fwdB),
    .o_stage_valid(stageValid),
    .o_kill_cnt   (killCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic [7:0] dst,
                               input logic wr, input logic st, input logic fl);
    inData  = d;
    inValid = v;
    inDst   = dst;
    inWr    = wr;
    stall   = st;
    flush   = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two valid entries into the pipe, then a flush with a valid incoming entry: 3 kills.
  task automatic fillFlush();
    applyStimulus(8'hC1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    step();
    step();
    applyStimulus(8'hC2, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
    step();
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    raAddr = 8'h00;
    rbAddr = 8'h00;
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_out", {24'd0, outData}, 32'h0);
    checkOutput("rst_valid", {30'd0, stageValid}, 32'h0);
    checkOutput("rst_kill", {24'd0, killCnt}, 32'h0);
    checkOutput("rst_fwd", {28'd0, fwdA, fwdB}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Stream 0x11, 0x22, 0x33
    applyStimulus(8'h11, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stream_s1only", {30'd0, stageValid}, 32'h1);
    applyStimulus(8'h22, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stream_out11", {23'd0, outValid, outData}, 32'h111);
    applyStimulus(8'h33, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stream_out22", {23'd0, outValid, outData}, 32'h122);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("stream_out33", {23'd0, outValid, outData}, 32'h133);
    checkOutput("stream_outdst", {24'd0, outDst}, 32'h3);
    checkOutput("stream_bubble_s1", {30'd0, stageValid}, 32'h2);
    step();
    checkOutput("stream_drained", {23'd0, outValid, outData}, 32'h0);

    // Stall three cycles with 0x22 in stage 1 and 0x21 in stage 2
    applyStimulus(8'h21, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h22, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h99, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_out", {23'd0, outValid, outData}, 32'h121);
      checkOutput("stall_valid", {30'd0, stageValid}, 32'h3);
    end
    applyStimulus(8'h23, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("resume_out22", {23'd0, outValid, outData}, 32'h122);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("resume_out23", {23'd0, outValid, outData}, 32'h123);
    step();
    checkOutput("resume_empty", {30'd0, stageValid}, 32'h0);

    // Full flush with valid incoming entry, then flush while stalled
    applyStimulus(8'h31, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h32, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(8'h33, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("flush_valid", {30'd0, stageValid}, 32'h0);
    checkOutput("flush_out", {24'd0, outData}, 32'h0);
    checkOutput("flush_kill3", {24'd0, killCnt}, 32'd3);
    applyStimulus(8'h41, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    applyStimulus(8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("flushstall_valid", {30'd0, stageValid}, 32'h0);
    checkOutput("flushstall_kill5", {24'd0, killCnt}, 32'd5);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("noflush_kill5", {24'd0, killCnt}, 32'd5);

    // Forwarding lookup
    applyStimulus(8'h51, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(8'h52, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    raAddr = 8'hE0;
    rbAddr = 8'h12;
    #1;
    checkOutput("fwd_a_youngest", {30'd0, fwdA}, 32'd1);
    checkOutput("fwd_b_nomatch", {30'd0, fwdB}, 32'd0);
    rbAddr = 8'hE0;
    #1;
    checkOutput("fwd_b_youngest", {30'd0, fwdB}, 32'd1);
    applyStimulus(8'h00, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("fwd_a_stage2", {30'd0, fwdA}, 32'd2);
    applyStimulus(8'h61, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("fwd_a_nowr", {30'd0, fwdA}, 32'd0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    raAddr = 8'h00;
    rbAddr = 8'h00;
    #1;
    checkOutput("fwd_invalid_stage", {28'd0, fwdA, fwdB}, 32'd0);

    // Kill counter saturation: 5 + 3 per round
    fillFlush();
    checkOutput("kill_round1", {24'd0, killCnt}, 32'd8);
    for (int r = 1; r < 83; r++) fillFlush();
    checkOutput("kill_254", {24'd0, killCnt}, 32'd254);
    fillFlush();
    checkOutput("kill_sat255", {24'd0, killCnt}, 32'd255);
    fillFlush();
    checkOutput("kill_hold255", {24'd0, killCnt}, 32'd255);

    // Async reset mid-cycle while stalled and flushing
    applyStimulus(8'h71, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    raAddr = 8'hE0;
    step();
    step();
    checkOutput("prerst_fwd", {30'd0, fwdA}, 32'd1);
    applyStimulus(8'h72, 1'b1, 8'hE0, 1'b1, 1'b1, 1'b1);
    #3 rst = 1'b0;
    #1;
    checkOutput("midrst_valid", {30'd0, stageValid}, 32'h0);
    checkOutput("midrst_out", {23'd0, outValid, outData}, 32'h0);
    checkOutput("midrst_dstwr", {23'd0, outWr, outDst}, 32'h0);
    checkOutput("midrst_kill", {24'd0, killCnt}, 32'h0);
    checkOutput("midrst_fwd", {28'd0, fwdA, fwdB}, 32'h0);
    applyStimulus(8'h77, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step();
    checkOutput("first_capture", {30'd0, stageValid}, 32'h1);
    checkOutput("postrst_kill", {24'd0, killCnt}, 32'h0);
    applyStimulus(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("first_out", {23'd0, outValid, outData}, 32'h177);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
